// File: rtl/ssd_display_arb_pkg.sv
// Shared constants and helpers for the seven-segment display arbiter.
// Holds digit geometry, the blank code and the arbiter state encoding.
package ssd_display_arb_pkg;

   localparam int BCD_BIT_WIDTH = 4;
   localparam int SSD_NUM       = 4;
   localparam int DIG_BUS_W     = BCD_BIT_WIDTH * SSD_NUM;

   localparam logic [BCD_BIT_WIDTH-1:0] BLANK_CODE = 4'hF;
   localparam logic [1:0]               NO_OWNER   = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } arb_state_t;

   // Lowest set index wins; NO_OWNER when nothing is requested.
   function automatic logic [1:0] pick_first(input logic [2:0] r);
      logic [1:0] idx;
      idx = NO_OWNER;
      priority case (1'b1)
         r[0]:    idx = 2'd0;
         r[1]:    idx = 2'd1;
         r[2]:    idx = 2'd2;
         default: idx = NO_OWNER;
      endcase
      return idx;
   endfunction

   // Owner index to one-hot grant; no owner gives all zeros.
   function automatic logic [2:0] to_onehot(input logic [1:0] idx);
      logic [2:0] g;
      g = 3'b000;
      unique case (idx)
         2'd0:    g = 3'b001;
         2'd1:    g = 3'b010;
         2'd2:    g = 3'b100;
         default: g = 3'b000;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/ssd_display_arb_tick_gen.sv
// Free-running scan tick divider for the display scan controller.
// Counts 0..SCAN_DIV-1 and flags the last count of each period.
module ssd_tick_gen #(
   parameter int SCAN_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam logic [15:0] CNT_MAX = 16'(SCAN_DIV - 1);

   logic [15:0] cnt;

   // Wrapping period counter, never disturbed by arbitration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (cnt == CNT_MAX) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

   assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/ssd_display_arb.sv
// Three-way arbiter owning a shared four-digit seven-segment display.
// Ownership is held for a minimum number of scan ticks before handover.
module ssd_display_arb
   import ssd_display_arb_pkg::*;
#(
   parameter int SCAN_DIV   = 50000,
   parameter int HOLD_TICKS = 200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req,
   input  logic [15:0] req_digits0,
   input  logic [15:0] req_digits1,
   input  logic [15:0] req_digits2,
   output logic [2:0]  grant,
   output logic [1:0]  owner,
   output logic [3:0]  dig0,
   output logic [3:0]  dig1,
   output logic [3:0]  dig2,
   output logic [3:0]  dig3,
   output logic        scan_tick,
   output logic        blank
);

   localparam logic [7:0]           HOLD_INIT = 8'(HOLD_TICKS);
   localparam logic [DIG_BUS_W-1:0] BLANK_BUS = {SSD_NUM{BLANK_CODE}};

   arb_state_t           state;
   logic [7:0]           hold_cnt;
   logic [DIG_BUS_W-1:0] dig_q;

   logic [1:0]  first;
   logic        req_own;
   logic        hold_zero;
   logic        take;
   logic        go_idle;

   ssd_tick_gen #(
      .SCAN_DIV (SCAN_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (scan_tick)
   );

   function automatic logic [DIG_BUS_W-1:0] sel_digits(
      input logic [1:0] idx
   );
      logic [DIG_BUS_W-1:0] d;
      d = BLANK_BUS;
      unique case (idx)
         2'd0:    d = req_digits0;
         2'd1:    d = req_digits1;
         2'd2:    d = req_digits2;
         default: d = BLANK_BUS;
      endcase
      return d;
   endfunction

   // Handover decisions from the hold count registered this cycle.
   always_comb begin
      first     = pick_first(req);
      req_own   = |(req & grant);
      hold_zero = (hold_cnt == 8'd0);
      take      = 1'b0;
      go_idle   = 1'b0;
      if (hold_zero) begin
         if (req_own) begin
            take = (first < owner);
         end else begin
            take    = (first != NO_OWNER);
            go_idle = (first == NO_OWNER);
         end
      end
   end

   // Ownership FSM with registered grant, owner, blank and digits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         grant    <= 3'b000;
         owner    <= NO_OWNER;
         blank    <= 1'b1;
         dig_q    <= BLANK_BUS;
         hold_cnt <= 8'd0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (|req) begin
                  state    <= ST_OWN;
                  owner    <= first;
                  grant    <= to_onehot(first);
                  blank    <= 1'b0;
                  dig_q    <= sel_digits(first);
                  hold_cnt <= HOLD_INIT;
               end
            end
            ST_OWN: begin
               if (take) begin
                  owner    <= first;
                  grant    <= to_onehot(first);
                  dig_q    <= sel_digits(first);
                  hold_cnt <= HOLD_INIT;
               end else if (go_idle) begin
                  state    <= ST_IDLE;
                  owner    <= NO_OWNER;
                  grant    <= 3'b000;
                  blank    <= 1'b1;
                  dig_q    <= BLANK_BUS;
                  hold_cnt <= 8'd0;
               end else begin
                  if (scan_tick && !hold_zero) begin
                     hold_cnt <= hold_cnt - 8'd1;
                  end
                  if (req_own) begin
                     dig_q <= sel_digits(owner);
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign dig0 = dig_q[3:0];
   assign dig1 = dig_q[7:4];
   assign dig2 = dig_q[11:8];
   assign dig3 = dig_q[15:12];

endmodule
